mem_xbar_arbiter: RTL and testbench
===================================

# mem_xbar_arbiter

Parametrised N-master to single-port SRAM arbiter for the core's memory subsystem. It replaces the per-port grant flop, which simply granted one cycle after request, with a shared front end. Instruction fetch, data LSU and any further masters (debug, DMA) share one single-cycle SRAM macro through it. It adds fixed or round-robin arbitration, same-cycle grant, per-port response routing and an out-of-range error response.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting masters; port 0 is highest fixed priority.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- ADDR_W, 32, master address width (byte addresses).
- MEM_START, 32'h00000000, base byte address of the SRAM window.
- MEM_SIZE, 16384, window size in bytes; must be a power of two.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority.

Ports (all master ports are flattened, with port i in slice i):
- Clock and reset are fixed: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_req_i  in  NUM_PORTS  request per port.
- m_we_i  in  NUM_PORTS  write enable per port.
- m_be_i  in  NUM_PORTS*DATA_W/8  byte enables.
- m_addr_i  in  NUM_PORTS*ADDR_W  byte addresses.
- m_wdata_i  in  NUM_PORTS*DATA_W  write data.
- m_gnt_o  out  NUM_PORTS  grant; one-hot or zero.
- m_rvalid_o  out  NUM_PORTS  response valid; one-hot or zero.
- m_rdata_o  out  NUM_PORTS*DATA_W  read data; shared bus replicated to every port.
- m_err_o  out  NUM_PORTS  error flag; qualified by m_rvalid_o.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_W/8  SRAM byte enables.
- mem_addr_o  out  MEM_AW  SRAM word address, where MEM_AW = clog2(MEM_SIZE/(DATA_W/8)).
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_rdata_i  in  DATA_W  SRAM read data, valid one cycle after mem_req_o.

## Operation
- **Winner selection:** each cycle, at most one requesting port wins; the winner's m_gnt_o goes high combinationally in the same cycle.
- **Fixed mode (RR_EN=0):** the lowest requesting index wins.
- **Round-robin mode (RR_EN=1):** search starts at rr_ptr and wraps modulo NUM_PORTS. After each grant, rr_ptr = winner+1, wrapping NUM_PORTS-1 to 0. rr_ptr holds when there is no grant.
- **Address decode:** in_range = (addr - MEM_START) < MEM_SIZE, using unsigned ADDR_W arithmetic.
  - In range: mem_req_o=1 and mem_addr_o = (addr - MEM_START) >> clog2(DATA_W/8). we, be and wdata pass through from the winner.
  - Out of range: the request is still granted, but mem_req_o=0 and nothing is written.
- **Response register:** captures {valid, port id, err} on grant.
  - Next cycle, m_rvalid_o[id]=1.
  - Read data: m_rdata_o carries mem_rdata_i, or 0 on error or write.
  - m_err_o[id] = err.
- Writes also produce exactly one rvalid with err=0 (or err=1 if out of range).
- **Throughput:** a grant is allowed every cycle, including in the same cycle as an rvalid. This gives back-to-back throughput of 1 access/cycle.
- **Idle bus:** when there is no winner, mem_* outputs are driven to 0.

## Timing
- **Reset values:** m_gnt_o=0, m_rvalid_o=0, m_err_o=0, m_rdata_o=0, mem_req_o=0, rr_ptr=0, response register cleared.
- **Latency:**
  - req to gnt: 0 cycles.
  - gnt to rvalid: exactly 1 cycle.
  - No port ever has more than one outstanding response.
- **Master rules:** a master must hold req/addr/we/be/wdata stable until gnt. It may drop req without a grant; no state is kept for it.
- **Simultaneous requests:** only the winner sees gnt; losers retry in later cycles.
- **Reset mid-operation:** a pending response is discarded, and no rvalid follows reset release.
- **Boundary addresses:**
  - MEM_START+MEM_SIZE-1 is in range.
  - MEM_START+MEM_SIZE is an error.
  - Addresses below MEM_START wrap to large unsigned values and are errors.
- **Sequential elements:** only rr_ptr and the response register. All other paths are combinational from inputs.

## Structure
- Shared package mem_arb_pkg holds the ARB_FIXED/ARB_RR mode constants and a clog2 helper function.
- Sub-module rr_arbiter takes (NUM_PORTS, RR_EN): req vector in, one-hot grant plus binary index out, and owns rr_ptr. The top level handles decode, muxing and the response register.
- Target size is roughly 200 lines total.

## Test plan
- **Single master read:** port0 writes 0xDEADBEEF to 0x10 with be=4'hF, then reads 0x10 → gnt same cycle, rvalid next cycle, rdata=0xDEADBEEF, err=0, mem_addr_o=4.
- **Fixed priority:** RR_EN=0, ports 0 and 1 request continuously for 4 cycles → port0 is granted all 4 cycles, and port1 only after port0 drops req.
- **Round-robin:** RR_EN=1, NUM_PORTS=3, all request for 6 cycles → grant order 0,1,2,0,1,2, each rvalid routed to the matching port one cycle later.
- **Out of range:** read to 0x4000 with MEM_SIZE=16384 → gnt=1, mem_req_o=0, next cycle rvalid=1, err=1, rdata=0. A write there leaves SRAM contents unchanged.
- **Byte write:** write 0x11223344 with be=4'b0100 over 0xFFFFFFFF, then read → 0xFF22FFFF.
- **Reset mid-operation:** assert rst_ni low in the cycle after a grant → no rvalid after release; all outputs 0; the first post-reset RR grant goes to port 0.

Source files
------------

// File: rtl/mem_xbar_arbiter_pkg.sv
// Shared definitions for the SRAM front-end arbiter: arbitration mode
// constants and a constant-evaluable ceil(log2) helper.
package mem_arb_pkg;

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_xbar_arbiter_if.sv
// Flattened master-side bus of the SRAM arbiter: port i lives in slice i
// of every vector, matching the arbiter's port layout.
interface mem_xbar_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          we;
    logic [NUM_PORTS*DATA_W/8-1:0] be;
    logic [NUM_PORTS*ADDR_W-1:0]   addr;
    logic [NUM_PORTS*DATA_W-1:0]   wdata;
    logic [NUM_PORTS-1:0]          gnt;
    logic [NUM_PORTS-1:0]          rvalid;
    logic [NUM_PORTS*DATA_W-1:0]   rdata;
    logic [NUM_PORTS-1:0]          err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_xbar_arbiter_rr_arbiter.sv
// Same-cycle request arbiter: fixed priority (lowest index) or round-robin
// starting at rr_ptr, which advances past each winner.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    parameter bit  RR_EN     = ARB_RR,
    localparam int IDX_W     = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        int start;
        int p;
        // NOTE: every output gets a default before the search loop, so no path leaves a value held and no latch is inferred.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        start = (RR_EN == ARB_RR) ? int'(rr_ptr) : 0;
        p     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = (start + k) % NUM_PORTS;
            if (!valid && req[p]) begin
                gnt[p] = 1'b1;
                idx    = IDX_W'(p);
                valid  = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments and an async reset, so every reader sees the pre-edge value and reset needs no clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (valid) begin
            rr_ptr <= (idx == IDX_W'(NUM_PORTS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_xbar_arbiter.sv
// N-master front end for one single-cycle SRAM: same-cycle grant, address
// window decode, and a one-entry response register that routes rvalid/err.
module mem_xbar_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                NUM_PORTS = 2,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_START = '0,
    parameter int                MEM_SIZE  = 16384,
    parameter bit                RR_EN     = ARB_RR,
    localparam int               BE_W      = DATA_W / 8,
    localparam int               MEM_AW    = clog2(MEM_SIZE / BE_W)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS-1:0]        m_req_i,
    input  logic [NUM_PORTS-1:0]        m_we_i,
    input  logic [NUM_PORTS*BE_W-1:0]   m_be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] m_wdata_i,
    output logic [NUM_PORTS-1:0]        m_gnt_o,
    output logic [NUM_PORTS-1:0]        m_rvalid_o,
    output logic [NUM_PORTS*DATA_W-1:0] m_rdata_o,
    output logic [NUM_PORTS-1:0]        m_err_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [BE_W-1:0]             mem_be_o,
    output logic [MEM_AW-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic [DATA_W-1:0]           mem_rdata_i
);

    localparam int OFF_W = clog2(BE_W);
    localparam int IDX_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic             valid;
        logic             we;
        logic             err;
        logic [IDX_W-1:0] id;
    } resp_t;

    logic [NUM_PORTS-1:0] gnt;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic                 win_we;
    logic [BE_W-1:0]      win_be;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [ADDR_W-1:0]    offset;
    logic                 in_range;
    logic                 access;
    logic [DATA_W-1:0]    rdata_bus;
    resp_t                resp;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .RR_EN     (RR_EN)
    ) u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .req   (m_req_i),
        .gnt   (gnt),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign m_gnt_o = gnt;

    always_comb begin
        win_we    = 1'b0;
        win_be    = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                win_we    = m_we_i[p];
                win_be    = m_be_i[p*BE_W +: BE_W];
                win_addr  = m_addr_i[p*ADDR_W +: ADDR_W];
                win_wdata = m_wdata_i[p*DATA_W +: DATA_W];
            end
        end
    end

    // Addresses below MEM_START wrap to huge offsets and fail the same compare.
    assign offset   = win_addr - MEM_START;
    assign in_range = offset < ADDR_W'(MEM_SIZE);
    assign access   = win_valid && in_range;

    assign mem_req_o   = access;
    assign mem_we_o    = access && win_we;
    assign mem_be_o    = access ? win_be : '0;
    assign mem_addr_o  = access ? offset[OFF_W +: MEM_AW] : '0;
    assign mem_wdata_o = access ? win_wdata : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp <= '0;
        end else begin
            resp.valid <= win_valid;
            if (win_valid) begin
                resp.we  <= win_we;
                resp.err <= !in_range;
                resp.id  <= win_idx;
            end
        end
    end

    assign rdata_bus = (resp.valid && !resp.we && !resp.err) ? mem_rdata_i : '0;
    assign m_rdata_o = {NUM_PORTS{rdata_bus}};

    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_rvalid_o[p] = resp.valid && (resp.id == IDX_W'(p));
            m_err_o[p]    = resp.valid && (resp.id == IDX_W'(p)) && resp.err;
        end
    end

endmodule

// File: tb/tb_mem_xbar_arbiter.sv
// Scoreboard bench: a round-robin 3-port instance and a fixed-priority
// 2-port instance, each backed by a behavioural single-cycle SRAM.
`timescale 1ns/1ps
module tb_mem_xbar_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int          dut;
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_xbar_arbiter_if #(.NUM_PORTS(3), .DATA_W(32), .ADDR_W(32)) bus_rr ();
    mem_xbar_arbiter_if #(.NUM_PORTS(3), .DATA_W(32), .ADDR_W(32)) bus_fx ();

    logic [1:0]  fx_gnt, fx_rvalid, fx_err;
    logic [63:0] fx_rdata;
    logic        rr_mreq, rr_mwe, fx_mreq, fx_mwe;
    logic [3:0]  rr_mbe, fx_mbe;
    logic [11:0] rr_maddr, fx_maddr;
    logic [31:0] rr_mwdata, fx_mwdata;
    logic [1:0]        mem_req, mem_we;
    logic [1:0][3:0]   mem_be;
    logic [1:0][11:0]  mem_addr;
    logic [1:0][31:0]  mem_wdata;
    logic [1:0][31:0]  mem_rdata;
    logic [31:0]       sram [2][4096];

    assign mem_req   = {fx_mreq, rr_mreq};
    assign mem_we    = {fx_mwe, rr_mwe};
    assign mem_be    = {fx_mbe, rr_mbe};
    assign mem_addr  = {fx_maddr, rr_maddr};
    assign mem_wdata = {fx_mwdata, rr_mwdata};
    assign bus_fx.gnt    = {1'b0, fx_gnt};
    assign bus_fx.rvalid = {1'b0, fx_rvalid};
    assign bus_fx.err    = {1'b0, fx_err};
    assign bus_fx.rdata  = {32'h0, fx_rdata};

    mem_xbar_arbiter #(
        .NUM_PORTS(3), .DATA_W(32), .ADDR_W(32), .MEM_START(32'h0),
        .MEM_SIZE(16384), .RR_EN(ARB_RR)
    ) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(bus_rr.req), .m_we_i(bus_rr.we), .m_be_i(bus_rr.be),
        .m_addr_i(bus_rr.addr), .m_wdata_i(bus_rr.wdata),
        .m_gnt_o(bus_rr.gnt), .m_rvalid_o(bus_rr.rvalid),
        .m_rdata_o(bus_rr.rdata), .m_err_o(bus_rr.err),
        .mem_req_o(rr_mreq), .mem_we_o(rr_mwe), .mem_be_o(rr_mbe),
        .mem_addr_o(rr_maddr), .mem_wdata_o(rr_mwdata), .mem_rdata_i(mem_rdata[0])
    );

    mem_xbar_arbiter #(
        .NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .MEM_START(32'h0),
        .MEM_SIZE(16384), .RR_EN(ARB_FIXED)
    ) u_fx (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(bus_fx.req[1:0]), .m_we_i(bus_fx.we[1:0]), .m_be_i(bus_fx.be[7:0]),
        .m_addr_i(bus_fx.addr[63:0]), .m_wdata_i(bus_fx.wdata[63:0]),
        .m_gnt_o(fx_gnt), .m_rvalid_o(fx_rvalid), .m_rdata_o(fx_rdata), .m_err_o(fx_err),
        .mem_req_o(fx_mreq), .mem_we_o(fx_mwe), .mem_be_o(fx_mbe),
        .mem_addr_o(fx_maddr), .mem_wdata_o(fx_mwdata), .mem_rdata_i(mem_rdata[1])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_req[d]) begin
                if (mem_we[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[d][b]) sram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
                    end
                end else begin
                    mem_rdata[d] <= sram[d][mem_addr[d]];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [2:0] gnt_of(input int d);
        return (d == 0) ? bus_rr.gnt : bus_fx.gnt;
    endfunction

    function automatic logic [2:0] rvalid_of(input int d);
        return (d == 0) ? bus_rr.rvalid : bus_fx.rvalid;
    endfunction

    function automatic logic [2:0] err_of(input int d);
        return (d == 0) ? bus_rr.err : bus_fx.err;
    endfunction

    function automatic logic [31:0] rdata_of(input int d, input int p);
        logic [95:0] r;
        r = (d == 0) ? bus_rr.rdata : bus_fx.rdata;
        return r[p*32 +: 32];
    endfunction

    task automatic clr_all();
        bus_rr.req = '0; bus_rr.we = '0; bus_rr.be = '0; bus_rr.addr = '0; bus_rr.wdata = '0;
        bus_fx.req = '0; bus_fx.we = '0; bus_fx.be = '0; bus_fx.addr = '0; bus_fx.wdata = '0;
    endtask

    task automatic set_req(input int d, input int p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            bus_rr.req[p] = 1'b1; bus_rr.we[p] = we; bus_rr.be[p*4 +: 4] = be;
            bus_rr.addr[p*32 +: 32] = addr; bus_rr.wdata[p*32 +: 32] = wdata;
        end else begin
            bus_fx.req[p] = 1'b1; bus_fx.we[p] = we; bus_fx.be[p*4 +: 4] = be;
            bus_fx.addr[p*32 +: 32] = addr; bus_fx.wdata[p*32 +: 32] = wdata;
        end
    endtask

    // One clock of the current stimulus: check grant and SRAM strobe mid-cycle,
    // queue the response due next cycle, then return just after the edge.
    task automatic step(input int d, input int win, input logic exp_req,
                        input logic [11:0] exp_maddr, input logic exp_err, input logic [31:0] exp_rdata);
        @(negedge clk);
        check($sformatf("d%0d gnt", d), gnt_of(d), (win < 0) ? 0 : (1 << win));
        check($sformatf("d%0d mem_req", d), mem_req[d], exp_req);
        if (exp_req) check($sformatf("d%0d mem_addr", d), mem_addr[d], exp_maddr);
        else check($sformatf("d%0d mem_we", d), mem_we[d], 0);
        if (win < 0) begin
            check($sformatf("d%0d idle mem_addr", d), mem_addr[d], 0);
            check($sformatf("d%0d idle mem_wdata", d), mem_wdata[d], 0);
            check($sformatf("d%0d idle mem_be", d), mem_be[d], 0);
        end else begin
            sb_q.push_back('{dut: d, port: win, err: exp_err, rdata: exp_rdata, due: cycle + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int d, input int p, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic exp_req,
                          input logic [11:0] exp_maddr, input logic exp_err, input logic [31:0] exp_rdata);
        clr_all();
        set_req(d, p, we, be, addr, wdata);
        step(d, p, exp_req, exp_maddr, exp_err, exp_rdata);
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d gnt", tag, d), gnt_of(d), 0);
            check($sformatf("%s d%0d rvalid", tag, d), rvalid_of(d), 0);
            check($sformatf("%s d%0d err", tag, d), err_of(d), 0);
            check($sformatf("%s d%0d mem_req", tag, d), mem_req[d], 0);
            for (int p = 0; p < 3; p++) check($sformatf("%s d%0d rdata%0d", tag, d, p), rdata_of(d, p), 0);
        end
    endtask

    // Monitor: every rvalid pops the oldest expectation; overdue entries are misses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int d = 0; d < 2; d++) begin
                    logic [2:0] rv;
                    exp_t       e;
                    rv = rvalid_of(d);
                    if (rv != 3'b0) begin
                        if (sb_q.size() == 0) begin
                            check($sformatf("d%0d unexpected rvalid", d), rv, 0);
                        end else begin
                            e = sb_q.pop_front();
                            check("rsp dut", d, e.dut);
                            check($sformatf("d%0d rsp rvalid", d), rv, 3'b1 << e.port);
                            check($sformatf("d%0d rsp err", d), err_of(d), e.err ? (3'b1 << e.port) : 3'b0);
                            check($sformatf("d%0d rsp rdata", d), rdata_of(d, e.port), e.rdata);
                            check($sformatf("d%0d rsp cycle", d), cycle, e.due);
                        end
                    end
                end
                if (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL missing rvalid: d%0d port %0d got none expected one at cycle %0d",
                             sb_q[0].dut, sb_q[0].port, sb_q[0].due);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected end before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rr_data [3];
        rr_data = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};
        rst_n = 1'b0;
        clr_all();
        @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed-priority instance: single master write/read, then priority.
        single(1, 0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b1, 12'h004, 1'b0, 32'h0);
        single(1, 0, 1'b0, 4'hF, 32'h10, 32'h0,         1'b1, 12'h004, 1'b0, 32'hDEAD_BEEF);
        single(1, 1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b1, 12'h008, 1'b0, 32'h0);
        clr_all();
        set_req(1, 0, 1'b0, 4'hF, 32'h10, 32'h0);
        set_req(1, 1, 1'b0, 4'hF, 32'h20, 32'h0);
        repeat (4) step(1, 0, 1'b1, 12'h004, 1'b0, 32'hDEAD_BEEF);
        bus_fx.req[0] = 1'b0;
        step(1, 1, 1'b1, 12'h008, 1'b0, 32'hCAFE_F00D);

        // Window boundaries and out-of-range protection.
        single(1, 0, 1'b1, 4'hF, 32'h0,         32'h1234_5678, 1'b1, 12'h000, 1'b0, 32'h0);
        single(1, 0, 1'b1, 4'hF, 32'h3FFF,      32'hA5A5_A5A5, 1'b1, 12'hFFF, 1'b0, 32'h0);
        single(1, 0, 1'b0, 4'hF, 32'h3FFC,      32'h0,         1'b1, 12'hFFF, 1'b0, 32'hA5A5_A5A5);
        single(1, 0, 1'b0, 4'hF, 32'h4000,      32'h0,         1'b0, 12'h000, 1'b1, 32'h0);
        single(1, 1, 1'b1, 4'hF, 32'h4000,      32'h0BAD_F00D, 1'b0, 12'h000, 1'b1, 32'h0);
        single(1, 0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         1'b0, 12'h000, 1'b1, 32'h0);
        single(1, 0, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1, 12'h000, 1'b0, 32'h1234_5678);

        // Byte-lane write merge.
        single(1, 0, 1'b1, 4'hF,    32'h30, 32'hFFFF_FFFF, 1'b1, 12'h00C, 1'b0, 32'h0);
        single(1, 0, 1'b1, 4'b0100, 32'h30, 32'h1122_3344, 1'b1, 12'h00C, 1'b0, 32'h0);
        single(1, 0, 1'b0, 4'hF,    32'h30, 32'h0,         1'b1, 12'h00C, 1'b0, 32'hFF22_FFFF);
        clr_all();
        step(1, -1, 1'b0, 12'h0, 1'b0, 32'h0);

        // Round-robin instance: preload, then all three request for six cycles.
        for (int p = 0; p < 3; p++)
            single(0, p, 1'b1, 4'hF, 32'h100 + 32'(4*p), rr_data[p], 1'b1, 12'h040 + 12'(p), 1'b0, 32'h0);
        clr_all();
        for (int p = 0; p < 3; p++) set_req(0, p, 1'b0, 4'hF, 32'h100 + 32'(4*p), 32'h0);
        for (int c = 0; c < 6; c++)
            step(0, c % 3, 1'b1, 12'h040 + 12'(c % 3), 1'b0, rr_data[c % 3]);

        // Reset one cycle after a grant: the pending response must vanish.
        single(0, 1, 1'b0, 4'hF, 32'h104, 32'h0, 1'b1, 12'h041, 1'b0, rr_data[1]);
        clr_all();
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_quiet("mid reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin
            step(0, -1, 1'b0, 12'h0, 1'b0, 32'h0);
            check("post-reset rvalid", rvalid_of(0), 0);
        end
        for (int p = 0; p < 3; p++) set_req(0, p, 1'b0, 4'hF, 32'h100 + 32'(4*p), 32'h0);
        step(0, 0, 1'b1, 12'h040, 1'b0, rr_data[0]);
        clr_all();
        repeat (2) step(0, -1, 1'b0, 12'h0, 1'b0, 32'h0);

        check("scoreboard drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
